// File: rtl/snac_port_scanner.sv
`timescale 1ns/1ps
// snac_port_scanner: time-multiplexes the SNAC user port between one or two Atari controllers.
// Optional SNAC_DEBOUNCE_EN: a slot whose samples disagree is rejected (glitch) instead of committed.
module snac_port_scanner #(
    parameter int unsigned SETTLE_CYCLES = 32,
    parameter int unsigned SAMPLES       = 4
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       two_player,
    input  logic       swap,
    input  logic [7:0] user_in,
    output logic [7:0] user_out,
    output logic [2:0] user_mode,
    output logic [4:0] joy_a,
    output logic [4:0] joy_b,
    output logic [1:0] pad_a,
    output logic [1:0] pad_b,
    output logic       upd,
    output logic       glitch
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_COMMIT
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLES - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       sel_q, sel_d;
    logic       mode_q, mode_d;
    logic [6:0] s1_q, s1_d;
    logic [6:0] s2_q, s2_d;
    logic [7:0] samp_q, samp_d;
    logic       upd_q, upd_d;
    logic [4:0] joy_a_q, joy_a_d;
    logic [4:0] joy_b_q, joy_b_d;
    logic [1:0] pad_a_q, pad_a_d;
    logic [1:0] pad_b_q, pad_b_d;
    logic [7:0] user_out_q, user_out_d;
    logic [2:0] user_mode_q, user_mode_d;
    logic [6:0] slot_a, slot_b;
    logic       commit_ok;
    logic       unused_samp_bits;

`ifdef SNAC_DEBOUNCE_EN
    logic [7:0] ref_q, ref_d;
    logic       mis_q, mis_d;
    logic       glitch_q, glitch_d;

    assign commit_ok = ~mis_q;
`else
    assign commit_ok = 1'b1;
`endif

    // Slot layout: {fire, up, down, left, right, pad1, pad0}; joystick lines are active-low on the port.
    function automatic logic [6:0] port_to_slot(input logic [7:0] v);
        return {~v[3], ~v[5], ~v[7], ~v[1], ~v[2], v[2], v[1]};
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        mode_d  = mode_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        samp_d  = samp_q;
        upd_d   = 1'b0;
`ifdef SNAC_DEBOUNCE_EN
        ref_d    = ref_q;
        mis_d    = mis_q;
        glitch_d = 1'b0;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_SETTLE;
                    cnt_d   = 8'd0;
                    sel_d   = 1'b1;
                end
            end

            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            ST_SAMPLE: begin
                samp_d = user_in;
`ifdef SNAC_DEBOUNCE_EN
                if (cnt_q == 8'd0) begin
                    ref_d = user_in;
                    mis_d = 1'b0;
                end else if (user_in != ref_q) begin
                    mis_d = 1'b1;
                end
`endif
                if (cnt_q == SAMPLE_LAST) begin
                    state_d = ST_COMMIT;
                    cnt_d   = 8'd0;
                    // Pulses are decided here so they are high during the COMMIT cycle itself.
`ifdef SNAC_DEBOUNCE_EN
                    upd_d    = ~mis_d;
                    glitch_d = mis_d;
`else
                    upd_d    = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            ST_COMMIT: begin
                if (commit_ok) begin
                    if (sel_q) begin
                        s1_d = port_to_slot(samp_q);
                    end else begin
                        s2_d = port_to_slot(samp_q);
                    end
                end
                // Leaving two-player mode drops the stale second controller.
                if (mode_q && !two_player) begin
                    s2_d = 7'd0;
                end
                mode_d  = two_player;
                sel_d   = two_player ? ~sel_q : 1'b1;
                state_d = ST_SETTLE;
                cnt_d   = 8'd0;
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
            sel_d   = 1'b1;
            mode_d  = 1'b0;
            s1_d    = 7'd0;
            s2_d    = 7'd0;
            upd_d   = 1'b0;
`ifdef SNAC_DEBOUNCE_EN
            mis_d    = 1'b0;
            glitch_d = 1'b0;
`endif
        end
    end

    // Outputs are built from next-state slots so committed data shows one cycle after COMMIT.
    always_comb begin
        slot_a = 7'd0;
        slot_b = 7'd0;
        if (mode_d) begin
            slot_a = swap ? s2_d : s1_d;
            slot_b = swap ? s1_d : s2_d;
        end else if (swap) begin
            slot_b = s1_d;
        end else begin
            slot_a = s1_d;
        end
        joy_a_d     = slot_a[6:2];
        pad_a_d     = slot_a[1:0];
        joy_b_d     = slot_b[6:2];
        pad_b_d     = slot_b[1:0];
        user_out_d  = mode_d ? {3'b111, sel_d, 4'b1111} : 8'hFF;
        user_mode_d = mode_d ? 3'b100 : 3'b000;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            sel_q       <= 1'b1;
            mode_q      <= 1'b0;
            s1_q        <= 7'd0;
            s2_q        <= 7'd0;
            samp_q      <= 8'hFF;
            upd_q       <= 1'b0;
            joy_a_q     <= 5'd0;
            joy_b_q     <= 5'd0;
            pad_a_q     <= 2'd0;
            pad_b_q     <= 2'd0;
            user_out_q  <= 8'hFF;
            user_mode_q <= 3'b000;
`ifdef SNAC_DEBOUNCE_EN
            ref_q       <= 8'hFF;
            mis_q       <= 1'b0;
            glitch_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            mode_q      <= mode_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            samp_q      <= samp_d;
            upd_q       <= upd_d;
            joy_a_q     <= joy_a_d;
            joy_b_q     <= joy_b_d;
            pad_a_q     <= pad_a_d;
            pad_b_q     <= pad_b_d;
            user_out_q  <= user_out_d;
            user_mode_q <= user_mode_d;
`ifdef SNAC_DEBOUNCE_EN
            ref_q       <= ref_d;
            mis_q       <= mis_d;
            glitch_q    <= glitch_d;
`endif
        end
    end

    assign unused_samp_bits = ^{samp_q[6], samp_q[4], samp_q[0]};

    assign user_out  = user_out_q;
    assign user_mode = user_mode_q;
    assign joy_a     = joy_a_q;
    assign joy_b     = joy_b_q;
    assign pad_a     = pad_a_q;
    assign pad_b     = pad_b_q;
    assign upd       = upd_q;
`ifdef SNAC_DEBOUNCE_EN
    assign glitch    = glitch_q;
`else
    assign glitch    = 1'b0;
`endif

endmodule

// File: tb/tb_snac_port_scanner.sv
`timescale 1ns/1ps
// Bench for snac_port_scanner: directed test-plan steps plus random stimulus against a
// timeline/queue model of the slot schedule (slot position = cycles since enable mod P).
module tb_snac_port_scanner;

    localparam int SETTLE = 32;
    localparam int NSAMP  = 4;
    localparam int P      = SETTLE + NSAMP + 1;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       two_player;
    logic       swap;
    logic [7:0] user_in;
    logic [7:0] user_out;
    logic [2:0] user_mode;
    logic [4:0] joy_a, joy_b;
    logic [1:0] pad_a, pad_b;
    logic       upd, glitch;

    snac_port_scanner #(
        .SETTLE_CYCLES(SETTLE),
        .SAMPLES      (NSAMP)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .enable    (enable),
        .two_player(two_player),
        .swap      (swap),
        .user_in   (user_in),
        .user_out  (user_out),
        .user_mode (user_mode),
        .joy_a     (joy_a),
        .joy_b     (joy_b),
        .pad_a     (pad_a),
        .pad_b     (pad_b),
        .upd       (upd),
        .glitch    (glitch)
    );

    always #5 clk_sys = ~clk_sys;

    int    n_cmp;
    int    n_err;
    string phase;
    bit    resp_on;

    // Reference model: position in the slot timeline plus the samples gathered in this slot.
    int         m_n;
    bit         m_sel;
    bit         m_mode;
    logic [6:0] m_s1, m_s2;
    logic [7:0] m_samp[$];
    logic [4:0] e_joy_a, e_joy_b;
    logic [1:0] e_pad_a, e_pad_b;
    logic       e_upd, e_glitch;
    logic [7:0] e_uo;
    logic [2:0] e_um;

    function automatic logic [6:0] to_slot(input logic [7:0] v);
        logic [4:0] j;
        j[4] = !v[3];   // fire
        j[3] = !v[5];   // up
        j[2] = !v[7];   // down
        j[1] = !v[1];   // left
        j[0] = !v[2];   // right
        return {j, v[2], v[1]};
    endfunction

    function automatic bit samples_ok();
`ifdef SNAC_DEBOUNCE_EN
        foreach (m_samp[i]) begin
            if (m_samp[i] != m_samp[0]) return 1'b0;
        end
`endif
        return 1'b1;
    endfunction

    task automatic model_outputs();
        logic [6:0] a, b;
        a = 7'd0;
        b = 7'd0;
        if (m_mode) begin
            a = swap ? m_s2 : m_s1;
            b = swap ? m_s1 : m_s2;
        end else if (swap) begin
            b = m_s1;
        end else begin
            a = m_s1;
        end
        e_joy_a = a[6:2];
        e_pad_a = a[1:0];
        e_joy_b = b[6:2];
        e_pad_b = b[1:0];
        e_uo    = m_mode ? {3'b111, m_sel, 4'b1111} : 8'hFF;
        e_um    = m_mode ? 3'b100 : 3'b000;
    endtask

    task automatic model_reset();
        m_n      = -1;
        m_sel    = 1'b1;
        m_mode   = 1'b0;
        m_s1     = 7'd0;
        m_s2     = 7'd0;
        m_samp.delete();
        e_upd    = 1'b0;
        e_glitch = 1'b0;
        model_outputs();
    endtask

    task automatic model_edge();
        int p;
        bit ok;
        if (!reset_n) begin
            model_reset();
            return;
        end
        if (!enable) begin
            model_reset();
            return;
        end
        if (m_n < 0) begin
            m_n = 0;
        end else begin
            p = m_n % P;
            if (p >= SETTLE && p < SETTLE + NSAMP) m_samp.push_back(user_in);
            if (p == P - 1) begin
                if (samples_ok()) begin
                    if (m_sel) m_s1 = to_slot(m_samp[$]);
                    else       m_s2 = to_slot(m_samp[$]);
                end
                if (m_mode && !two_player) m_s2 = 7'd0;
                m_sel  = two_player ? !m_sel : 1'b1;
                m_mode = two_player;
                m_samp.delete();
            end
            m_n++;
        end
        e_upd    = 1'b0;
        e_glitch = 1'b0;
        if (m_n % P == P - 1) begin
            ok    = samples_ok();
            e_upd = ok;
`ifdef SNAC_DEBOUNCE_EN
            e_glitch = !ok;
`endif
        end
        model_outputs();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s %s: observed 0x%0h expected 0x%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("joy_a",     32'(joy_a),     32'(e_joy_a));
        chk("joy_b",     32'(joy_b),     32'(e_joy_b));
        chk("pad_a",     32'(pad_a),     32'(e_pad_a));
        chk("pad_b",     32'(pad_b),     32'(e_pad_b));
        chk("upd",       32'(upd),       32'(e_upd));
        chk("glitch",    32'(glitch),    32'(e_glitch));
        chk("user_out",  32'(user_out),  32'(e_uo));
        chk("user_mode", 32'(user_mode), 32'(e_um));
    endtask

    task automatic tick();
        @(posedge clk_sys);
        model_edge();
        #1;
        if (resp_on) user_in = user_out[4] ? 8'h7F : 8'hFB;
        check_all();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         guard;
        int         last_tog;
        int         n_tog;
        int         k;
        logic       prev_sel;
        logic       sel_at;
        logic [7:0] base;
        logic [6:0] exp_slot;

        n_cmp   = 0;
        n_err   = 0;
        resp_on = 1'b0;

        // Reset with random inputs
        phase      = "reset";
        reset_n    = 1'b0;
        enable     = 1'b1;
        two_player = 1'b1;
        swap       = 1'b0;
        user_in    = 8'h00;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            enable     = 1'($urandom);
            two_player = 1'($urandom);
            swap       = 1'($urandom);
            user_in    = 8'($urandom);
            tick();
        end
        chk("rst_joy_a", 32'(joy_a), 32'd0);
        chk("rst_joy_b", 32'(joy_b), 32'd0);
        chk("rst_pads", 32'({pad_a, pad_b}), 32'd0);
        chk("rst_upd", 32'(upd), 32'd0);
        chk("rst_user_out", 32'(user_out), 32'hFF);
        chk("rst_user_mode", 32'(user_mode), 32'd0);
        enable     = 1'b0;
        two_player = 1'b0;
        swap       = 1'b0;
        reset_n    = 1'b1;
        tick();
        tick();

        // Single player, fire held
        phase   = "single";
        enable  = 1'b1;
        user_in = 8'hF7;
        for (int i = 0; i < P; i++) tick();
        chk("upd_at_commit", 32'(upd), 32'd1);
        tick();
        chk("joy_a", 32'(joy_a), 32'b10000);
        chk("pad_a", 32'(pad_a), 32'b11);
        chk("joy_b", 32'(joy_b), 32'd0);
        chk("pad_b", 32'(pad_b), 32'd0);
        swap = 1'b1;
        tick();
        chk("swap_joy_b", 32'(joy_b), 32'b10000);
        chk("swap_joy_a", 32'(joy_a), 32'd0);
        swap = 1'b0;
        tick();

        // Two player with a responder keyed on the select line
        phase      = "two_player";
        two_player = 1'b1;
        resp_on    = 1'b1;
        user_in    = user_out[4] ? 8'h7F : 8'hFB;
        prev_sel   = user_out[4];
        last_tog   = -1;
        n_tog      = 0;
        for (int i = 0; i < 6 * P; i++) begin
            tick();
            if (user_out[4] !== prev_sel) begin
                if (last_tog >= 0) chk("sel_period", 32'(i - last_tog), 32'(P));
                last_tog = i;
                n_tog++;
            end
            prev_sel = user_out[4];
        end
        chk("sel_toggles", 32'(n_tog >= 4), 32'd1);
        chk("user_mode", 32'(user_mode), 32'b100);
        chk("joy_a", 32'(joy_a), 32'b00100);
        chk("pad_a", 32'(pad_a), 32'b11);
        chk("joy_b", 32'(joy_b), 32'b00001);
        chk("pad_b", 32'(pad_b), 32'b01);
        swap = 1'b1;
        tick();
        chk("swap_joy_a", 32'(joy_a), 32'b00001);
        chk("swap_joy_b", 32'(joy_b), 32'b00100);
        swap = 1'b0;
        tick();

        // Fire line flips during the second sample of a slot
        phase = "debounce";
        guard = 0;
        while ((m_n % P) != SETTLE && guard < 2 * P) begin
            tick();
            guard++;
        end
        chk("align_sample", 32'(guard < 2 * P), 32'd1);
        resp_on = 1'b0;
        base    = 8'($urandom);
        base[5] = 1'b0;
        user_in = base;
        tick();
        user_in = base ^ 8'h08;
        tick();
        user_in = base;
        sel_at  = m_sel;
        guard   = 0;
        while ((m_n % P) != P - 1 && guard < P) begin
            tick();
            guard++;
        end
        chk("align_commit", 32'(guard < P), 32'd1);
`ifdef SNAC_DEBOUNCE_EN
        chk("glitch_pulse", 32'(glitch), 32'd1);
        chk("no_upd", 32'(upd), 32'd0);
        tick();
        chk("kept_joy_a", 32'(joy_a), 32'b00100);
        chk("kept_pad_a", 32'(pad_a), 32'b11);
        chk("kept_joy_b", 32'(joy_b), 32'b00001);
        chk("kept_pad_b", 32'(pad_b), 32'b01);
`else
        chk("upd_pulse", 32'(upd), 32'd1);
        chk("no_glitch", 32'(glitch), 32'd0);
        tick();
        exp_slot = to_slot(base);
        if (sel_at) chk("new_slot_a", 32'({joy_a, pad_a}), 32'(exp_slot));
        else        chk("new_slot_b", 32'({joy_b, pad_b}), 32'(exp_slot));
`endif
        resp_on = 1'b1;
        tick();

        // Random traffic against the model
        phase   = "random";
        resp_on = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            k = int'($urandom_range(0, 99));
            if (k < 12) user_in = 8'($urandom);
            if (k == 50) swap = ~swap;
            if ($urandom_range(0, 299) == 0) two_player = ~two_player;
            enable = ($urandom_range(0, 499) != 0);
            tick();
        end

        // Enable dropped in the middle of SETTLE
        phase      = "enable_drop";
        enable     = 1'b1;
        two_player = 1'b0;
        swap       = 1'b0;
        user_in    = 8'hF7;
        guard      = 0;
        while (!(m_n >= 0 && (m_n % P) == 10) && guard < 3 * P) begin
            tick();
            guard++;
        end
        chk("align_settle", 32'(guard < 3 * P), 32'd1);
        enable = 1'b0;
        tick();
        chk("off_joy", 32'({joy_a, joy_b}), 32'd0);
        chk("off_pad", 32'({pad_a, pad_b}), 32'd0);
        chk("off_user_out", 32'(user_out), 32'hFF);
        chk("off_user_mode", 32'(user_mode), 32'd0);
        enable = 1'b1;
        k      = 0;
        for (int i = 1; i <= 2 * P; i++) begin
            tick();
            if (upd === 1'b1) begin
                k = i;
                break;
            end
        end
        chk("reenable_latency", 32'(k), 32'(P));
        tick();
        chk("reenable_joy_a", 32'(joy_a), 32'b10000);

        // two_player cleared during the sample window of slot 2
        phase      = "mode_change";
        two_player = 1'b1;
        resp_on    = 1'b1;
        for (int i = 0; i < 3 * P; i++) tick();
        guard = 0;
        while (!(m_sel == 1'b0 && (m_n % P) == SETTLE + 1) && guard < 3 * P) begin
            tick();
            guard++;
        end
        chk("align_slot2", 32'(guard < 3 * P), 32'd1);
        two_player = 1'b0;
        guard      = 0;
        while ((m_n % P) != P - 1 && guard < P) begin
            tick();
            guard++;
        end
        chk("align_commit", 32'(guard < P), 32'd1);
        tick();
        chk("user_mode_off", 32'(user_mode), 32'd0);
        chk("user_out_ff", 32'(user_out), 32'hFF);
        chk("joy_b_clear", 32'(joy_b), 32'd0);
        chk("pad_b_clear", 32'(pad_b), 32'd0);
        chk("joy_a_kept", 32'(joy_a), 32'b00100);

        // Asynchronous reset in the middle of a slot
        phase = "reset_mid";
        guard = 0;
        while ((m_n % P) != SETTLE + 2 && guard < 2 * P) begin
            tick();
            guard++;
        end
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("joy_a", 32'(joy_a), 32'd0);
        chk("user_out", 32'(user_out), 32'hFF);
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < P + 2; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/snac_port_scanner.md
# snac_port_scanner

Sequencer for the SNAC user port: owns `user_out`/`user_mode` and time-multiplexes the shared USER_IN lines between one or two native Atari controllers. It drives the player-select line, waits for the external mux to settle, samples and optionally debounces the port, and publishes per-player joystick and paddle-button state. It sits between the top-level USER_IN/USER_OUT/USER_MODE pins and the joystick/paddle selection logic feeding `A2601top`.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 32: cycles held in SETTLE after the select line changes. Legal range 1..255.
- `SAMPLES`, default 4: consecutive port samples taken per slot. Legal range 1..16.

Ports:
- `clk_sys` in 1: single clock. Everything is in this domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: SNAC mode on (status serial mode).
- `two_player` in 1: 1 = multiplexed two-player mode, 0 = single player.
- `swap` in 1: exchange the A and B outputs.
- `user_in` in 8: raw port. Active-low lines: right=[2], left=[1], down=[7], up=[5], fire=[3].
- `user_out` out 8: port drive. Bit 4 is select.
- `user_mode` out 3: port mode.
- `joy_a`, `joy_b` out 5: {fire,up,down,left,right}, active-high pressed.
- `pad_a`, `pad_b` out 2: paddle buttons {user_in[2],user_in[1]}, passed through uninverted.
- `upd` out 1: one-cycle pulse when a slot commits.
- `glitch` out 1: one-cycle pulse when a slot sample is rejected.

## Operation
- Internal state: slot registers `s1`/`s2` (5-bit joystick + 2-bit paddle each), `sel`, and a counter.
- FSM states:
  - IDLE: when `enable`=1, go to SETTLE with cnt=0 and sel=1.
  - SETTLE: cnt++. At cnt==SETTLE_CYCLES-1, go to SAMPLE with cnt=0.
  - SAMPLE: runs for SAMPLES cycles. The first cycle loads `ref`=user_in. Each later cycle sets a sticky `mis` flag if user_in≠ref. After the last cycle, go to COMMIT.
  - COMMIT: one cycle.
    - If `mis`=0: write the slot (sel=1 → s1, sel=0 → s2), with joystick = ~{in[3],in[5],in[7],in[1],in[2]} and pad = {in[2],in[1]}. Pulse `upd`.
    - Otherwise: leave the slot unchanged and pulse `glitch`.
    - Next sel = two_player ? ~sel : 1. Go to SETTLE with cnt=0.
- Port drive:
  - Two-player mode: user_out = {3'b111, sel, 4'b1111}, user_mode = 3'b100.
  - Otherwise: user_out = 8'hFF, user_mode = 3'b000.
  - The drive is registered and follows the current `sel`.
- Output mapping (registered from the slots every cycle):
  - Two-player: joy_a/pad_a = swap ? s2 : s1; joy_b/pad_b = swap ? s1 : s2.
  - Single-player: the slot-1 value goes to A when swap=0, else to B. The other side is forced to 0.
- `two_player` is sampled only at COMMIT. A falling edge clears s2 at that COMMIT.
- `enable`=0 in any state: the next state is IDLE. s1, s2, all outputs and pulses clear to 0, user_out=8'hFF, user_mode=0.

## Timing
- Reset values:
  - State IDLE, sel=1, s1=s2=0.
  - joy_a/joy_b/pad_a/pad_b=0, upd=glitch=0.
  - user_out=8'hFF, user_mode=3'b000.
- Slot period P = SETTLE_CYCLES + SAMPLES + 1 (37 at defaults). The select line toggles every P cycles in two-player mode.
- Slot data appears on the joy/pad outputs 1 cycle after the COMMIT that wrote it. `upd` is asserted in the COMMIT cycle.
- A `swap` change is reflected on the outputs 1 cycle later. It does not alter sel or the FSM.
- SAMPLES=1: no comparison is made and the slot always commits.
- Counter width is sized for 255 and never wraps.
- Reset asserted mid-slot: immediate return to reset values. The partial sample is discarded.

## Configuration
- `SNAC_DEBOUNCE_EN` defined: SAMPLE compares as described, and a mismatch rejects the commit.
- `SNAC_DEBOUNCE_EN` undefined:
  - SAMPLE still lasts SAMPLES cycles, so P is unchanged.
  - COMMIT writes the value sampled in the last SAMPLE cycle. `mis` is ignored.
  - `glitch` is tied to 0.

## Test plan
- Reset test: drive reset_n=0 with random inputs. Require all joy/pad=0, upd=0, user_out=8'hFF, user_mode=0.
- Single-player test: enable=1, two_player=0, user_in=8'hF7.
  - After 38 cycles: joy_a=5'b10000, pad_a=2'b11, joy_b=0, pad_b=0.
  - Set swap=1: one cycle later joy_b=5'b10000 and joy_a=0.
- Two-player test: the bench returns 8'h7F when user_out[4]=1 and 8'hFB when user_out[4]=0.
  - Require user_mode=3'b100 and user_out[4] toggling every 37 cycles.
  - Require joy_a=5'b00100, pad_a=2'b11, joy_b=5'b00001, pad_b=2'b01.
- Debounce test (macro on): flip user_in[3] in the 2nd SAMPLE cycle. Require `glitch` to pulse in COMMIT with no `upd`, and the outputs unchanged. With the macro off, the last sample commits and `upd` pulses.
- Enable-drop test: deassert enable mid-SETTLE. Next cycle: IDLE, outputs 0, user_out=8'hFF. On re-enable, sel=1 and the first commit comes P cycles later.
- Mode-change test: clear two_player mid-SAMPLE of slot 2. At that COMMIT, s2 clears, sel returns to 1, user_mode goes to 0 next cycle, and joy_b goes to 0.
